// File: rtl/count_ctrl.sv
// count_ctrl: run/pause/clear sequencer driving a two-digit BCD counter datapath.
// Latency: key press acts 2 (sync) + DEB_CYCLES (debounce) cycles after the raw edge; step is combinational.
// Backpressure: none; step/load are single-cycle commands the datapath always accepts.

// Per-key synchroniser and debouncer producing a one-cycle press pulse.
module count_ctrl_deb #(
  parameter int DEB_CYCLES = 20000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_key,
  output logic o_press
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] C_MAX = CW'(DEB_CYCLES - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_lvl;
  logic [CW-1:0] r_cnt;
  logic          w_accept;

  // The counter measures how long the synchronised sample has disagreed with
  // the accepted level; a single agreeing sample restarts the measurement.
  assign w_accept = (r_s2 != r_lvl) && (r_cnt == C_MAX);
  // Press fires in the same cycle the level flips to 1; release edges are silent.
  assign o_press  = w_accept && r_s2;

  // Two-flop synchroniser for the asynchronous raw key.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_key;
      r_s2 <= r_s1;
    end
  end

  // Accept a new level after DEB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lvl <= 1'b0;
      r_cnt <= '0;
    end else if (r_s2 == r_lvl) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_lvl <= r_s2;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end
endmodule

module count_ctrl #(
  parameter int          TICK_DIV   = 1000000,
  parameter int          DEB_CYCLES = 20000,
  parameter logic [7:0]  PRESET     = 8'h60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_ss,
  input  logic       key_clr,
  input  logic       mode,
  input  logic [7:0] cnt_bcd,
  output logic       step,
  output logic       dir,
  output logic       load,
  output logic [7:0] load_val,
  output logic [1:0] state,
  output logic       alarm
);
  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_DONE  = 2'b11;

  localparam int DW = $clog2(TICK_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(TICK_DIV - 1);

  logic          w_ss_p;
  logic          w_clr_p;
  logic          w_term;
  logic          w_div_end;
  logic          w_start;
  logic [1:0]    r_state;
  logic [DW-1:0] r_div;
  logic          r_dir;
  logic          r_load;
  logic [7:0]    r_load_val;

  count_ctrl_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_ss (
    .clk     (clk),
    .rst     (rst),
    .i_key   (key_ss),
    .o_press (w_ss_p)
  );

  count_ctrl_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
    .clk     (clk),
    .rst     (rst),
    .i_key   (key_clr),
    .o_press (w_clr_p)
  );

  // Terminal count depends on the latched direction, not the live mode input.
  assign w_term    = r_dir ? (cnt_bcd == 8'h99) : (cnt_bcd == 8'h00);
  assign w_div_end = (r_div == DIV_MAX);
  // Clear outranks start/stop, so a start only counts when no clear coincides.
  assign w_start   = (r_state == S_IDLE) && w_ss_p && !w_clr_p;

  // Step is suppressed on terminal so the datapath never passes 99/00.
  assign step     = (r_state == S_RUN) && w_div_end && !w_term;
  assign dir      = r_dir;
  assign load     = r_load;
  assign load_val = r_load_val;
  assign state    = r_state;
  assign alarm    = (r_state == S_DONE);

  // Main sequencer: clear from anywhere, start/stop toggles, terminal stops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else if (w_clr_p) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_ss_p) r_state <= S_RUN;
        S_RUN: begin
          if (w_term)      r_state <= S_DONE;
          else if (w_ss_p) r_state <= S_PAUSE;
        end
        S_PAUSE: if (w_ss_p) r_state <= S_RUN;
        default: r_state <= S_DONE;
      endcase
    end
  end

  // Tick divider advances only in RUN and holds its phase across PAUSE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div <= '0;
    end else if (w_clr_p || w_start) begin
      r_div <= '0;
    end else if (r_state == S_RUN) begin
      r_div <= w_div_end ? '0 : r_div + DW'(1);
    end
  end

  // Direction is captured once per start so mid-run mode changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dir <= 1'b1;
    end else if (w_start) begin
      r_dir <= ~mode;
    end
  end

  // Preset load strobe follows a clear press by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_load     <= 1'b0;
      r_load_val <= 8'h00;
    end else begin
      r_load <= w_clr_p;
      if (w_clr_p) r_load_val <= mode ? PRESET : 8'h00;
    end
  end
endmodule

// File: tb/tb_count_ctrl.sv
// tb_count_ctrl: directed plus randomised bench for count_ctrl with a BCD counter model.
// Latency: the reference tracks the controller cycle by cycle from key history and run time.
// Backpressure: none; the bench datapath consumes every step/load.
module tb_count_ctrl;
  localparam int TICK = 4;
  localparam int DEB  = 3;

  logic       clk     = 1'b0;
  logic       rst     = 1'b1;
  logic       key_ss  = 1'b0;
  logic       key_clr = 1'b0;
  logic       mode    = 1'b0;
  logic [7:0] cnt_bcd = 8'h00;
  logic       step;
  logic       dir;
  logic       load;
  logic [7:0] load_val;
  logic [1:0] state;
  logic       alarm;

  int n_cmp = 0;
  int n_err = 0;

  count_ctrl #(.TICK_DIV(TICK), .DEB_CYCLES(DEB), .PRESET(8'h60)) dut (
    .clk      (clk),
    .rst      (rst),
    .key_ss   (key_ss),
    .key_clr  (key_clr),
    .mode     (mode),
    .cnt_bcd  (cnt_bcd),
    .step     (step),
    .dir      (dir),
    .load     (load),
    .load_val (load_val),
    .state    (state),
    .alarm    (alarm)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // BCD arithmetic done on the decimal value, wrapping 00..99.
  function automatic logic [7:0] bcd_add(input logic [7:0] v, input int delta);
    int n;
    n = (int'(v[7:4]) * 10 + int'(v[3:0]) + delta + 100) % 100;
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  function automatic bit is_term(input int d, input logic [7:0] c);
    return (d != 0) ? (c == 8'h99) : (c == 8'h00);
  endfunction

  // ---------------- reference model ----------------
  // Keys: raw value seen two edges earlier; a level is accepted once that
  // delayed value has differed from the accepted level DEB edges in a row.
  int k_d1[2], k_d2[2], k_lvl[2], k_run[2], m_press[2], m_raw[2];
  int m_samp;
  int m_state, m_runcyc, m_dir, m_load, m_load_val;
  bit m_term;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        k_d1[k] = 0; k_d2[k] = 0; k_lvl[k] = 0; k_run[k] = 0;
      end
      m_state = 0; m_runcyc = 0; m_dir = 1; m_load = 0; m_load_val = 0;
    end else begin
      m_raw[0] = int'(key_ss);
      m_raw[1] = int'(key_clr);
      for (int k = 0; k < 2; k++) begin
        m_samp   = k_d2[k];
        k_d2[k]  = k_d1[k];
        k_d1[k]  = m_raw[k];
        m_press[k] = 0;
        if (m_samp != k_lvl[k]) begin
          k_run[k]++;
          if (k_run[k] == DEB) begin
            k_lvl[k]   = m_samp;
            k_run[k]   = 0;
            m_press[k] = m_samp;
          end
        end else begin
          k_run[k] = 0;
        end
      end
      m_term = is_term(m_dir, cnt_bcd);
      m_load = 0;
      if (m_press[1] != 0) begin
        m_load     = 1;
        m_load_val = mode ? 8'h60 : 8'h00;
        m_state    = 0;
        m_runcyc   = 0;
      end else begin
        case (m_state)
          0: if (m_press[0] != 0) begin m_state = 1; m_dir = mode ? 0 : 1; m_runcyc = 0; end
          1: begin
            m_runcyc++;
            if (m_term) m_state = 3;
            else if (m_press[0] != 0) m_state = 2;
          end
          2: if (m_press[0] != 0) m_state = 1;
          default: ;
        endcase
      end
    end
  end

  // ---------------- bench datapath + per-cycle checks ----------------
  logic       pend_step = 0, pend_dir = 0, pend_load = 0;
  logic [7:0] pend_val = 0;
  int         n_steps = 0, n_trans = 0, prev_state = 0;
  logic       seen_load = 0;
  logic [7:0] seen_val = 0;
  logic [3:0] seen_state = 0;

  task automatic tick();
    logic       st, ld, dr, exp_step;
    logic [7:0] lv;
    @(negedge clk);
    exp_step = (m_state == 1) && ((m_runcyc % TICK) == TICK - 1) && !is_term(m_dir, cnt_bcd);
    check_val("state", state, m_state);
    check_val("dir", dir, m_dir);
    check_val("load", load, m_load);
    check_val("load_val", load_val, m_load_val);
    check_val("alarm", alarm, (m_state == 3));
    check_val("step", step, exp_step);
    check_val("step_load_excl", step & load, 0);
    st = step; ld = load; lv = load_val; dr = dir;
    // Datapath registers the command issued in the previous cycle.
    if (pend_step)      cnt_bcd = bcd_add(cnt_bcd, pend_dir ? 1 : -1);
    else if (pend_load) cnt_bcd = pend_val;
    pend_step = st; pend_dir = dr; pend_load = ld; pend_val = lv;
    if (st) n_steps++;
    if (ld) begin seen_load = 1; seen_val = lv; end
    seen_state[state] = 1'b1;
    if (int'(state) != prev_state) n_trans++;
    prev_state = int'(state);
  endtask

  task automatic press(input int which, input int hold);
    if (which[0]) key_ss = 1'b1;
    if (which[1]) key_clr = 1'b1;
    repeat (hold) tick();
    key_ss = 1'b0;
    key_clr = 1'b0;
    repeat (8) tick();
  endtask

  task automatic wait_state(input string tag, input logic [1:0] tgt, input int lim);
    int n;
    n = 0;
    while (state !== tgt && n < lim) begin tick(); n++; end
    check_val(tag, state, tgt);
  endtask

  initial begin
    int n;
    repeat (3) tick();
    check_val("rst_state", state, 2'b00);
    check_val("rst_dir", dir, 1'b1);
    check_val("rst_load_val", load_val, 8'h00);
    check_val("rst_alarm", alarm, 1'b0);
    rst = 1'b0;
    tick();

    // Start latency and first steps.
    key_ss = 1'b1; n_steps = 0;
    repeat (4) tick();
    check_val("start_lat4", state, 2'b00);
    tick();
    check_val("start_lat5", state, 2'b01);
    repeat (5) tick();
    key_ss = 1'b0;
    repeat (7) tick();
    check_val("cnt_after_3_steps", cnt_bcd, 8'h03);
    check_val("steps_3", n_steps, 3);

    // Bouncing key: exactly one press.
    n_trans = 0;
    for (int i = 0; i < 6; i++) begin key_ss = ~key_ss; tick(); end
    key_ss = 1'b1;
    repeat (10) tick();
    key_ss = 1'b0;
    repeat (8) tick();
    check_val("bounce_one_trans", n_trans, 1);
    check_val("bounce_paused", state, 2'b10);

    // Pause / resume around count 05.
    cnt_bcd = 8'h01;
    press(1, 8);
    n = 0;
    while (cnt_bcd != 8'h05 && n < 200) begin tick(); n++; end
    check_val("reach_05", cnt_bcd, 8'h05);
    key_ss = 1'b1;
    repeat (8) tick();
    key_ss = 1'b0;
    wait_state("pause", 2'b10, 20);
    n_steps = 0;
    repeat (20) tick();
    check_val("no_step_paused", n_steps, 0);
    check_val("still_paused", state, 2'b10);
    key_ss = 1'b1;
    wait_state("resume", 2'b01, 10);
    n = 0;
    while (n_steps == 0 && n < 10) begin tick(); n++; end
    check_val("resume_first_step", (n <= TICK), 1);
    key_ss = 1'b0;
    repeat (8) tick();

    // Down count from preset to DONE.
    mode = 1'b1; seen_load = 0;
    press(2, 8);
    check_val("clr_load_seen", seen_load, 1'b1);
    check_val("clr_load_val", seen_val, 8'h60);
    check_val("clr_state", state, 2'b00);
    check_val("clr_cnt", cnt_bcd, 8'h60);
    n_steps = 0;
    press(1, 8);
    wait_state("done_down", 2'b11, 400);
    check_val("done_alarm", alarm, 1'b1);
    check_val("done_cnt", cnt_bcd, 8'h00);
    check_val("down_steps", n_steps, 60);
    press(1, 8);
    check_val("done_ignores_ss", state, 2'b11);
    press(2, 8);
    check_val("done_clr_state", state, 2'b00);
    check_val("done_clr_alarm", alarm, 1'b0);

    // Up from 98: one step then DONE.
    mode = 1'b0;
    press(2, 8);
    cnt_bcd = 8'h98; n_steps = 0;
    press(1, 8);
    wait_state("done_up", 2'b11, 40);
    check_val("up_one_step", n_steps, 1);
    check_val("up_cnt_99", cnt_bcd, 8'h99);

    // Simultaneous start/stop and clear while running.
    mode = 1'b1;
    press(2, 8);
    mode = 1'b0;
    press(1, 8);
    check_val("run_before_both", state, 2'b01);
    mode = 1'b1; seen_state = '0; seen_load = 0;
    press(3, 8);
    check_val("both_no_pause", seen_state[2], 1'b0);
    check_val("both_load", seen_load, 1'b1);
    check_val("both_idle", state, 2'b00);

    // Asynchronous reset mid-run.
    mode = 1'b0;
    press(1, 8);
    repeat (3) tick();
    #1 rst = 1'b1;
    #1;
    check_val("arst_state", state, 2'b00);
    check_val("arst_step", step, 1'b0);
    check_val("arst_load", load, 1'b0);
    check_val("arst_load_val", load_val, 8'h00);
    check_val("arst_dir", dir, 1'b1);
    check_val("arst_alarm", alarm, 1'b0);
    repeat (2) tick();
    rst = 1'b0;
    pend_step = 0; pend_load = 0;
    tick();

    // Randomised keys, mode and counter preloads.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0)  key_ss  = ~key_ss;
      if ($urandom_range(0, 15) == 0) key_clr = ~key_clr;
      if ($urandom_range(0, 31) == 0) mode    = ~mode;
      if ($urandom_range(0, 63) == 0) begin
        case ($urandom_range(0, 3))
          0:       cnt_bcd = 8'h00;
          1:       cnt_bcd = 8'h99;
          2:       cnt_bcd = 8'h98;
          default: cnt_bcd = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        endcase
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
